// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder pipeline: skid-buffer FSM states and code-width limits.
// No logic, so no latency of its own.
// No flow control here; decoder_pipe handles backpressure.
package decoder_pkg;

  // Legal range for the code width parameter N_IN
  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 6;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_core.sv
// Combinational N_IN -> 2**N_IN decoder: one-hot, or thermometer when DECODER_PIPE_THERMO_EN is defined and thermo=1.
// Latency 0; pure combinational.
// No flow control; the caller samples word when it accepts a code.
module decoder_core
  import decoder_pkg::*;
#(
  parameter  int N_IN  = 3,
  localparam int OUT_W = 2**N_IN
) (
  input  logic [N_IN-1:0]  x,
`ifdef DECODER_PIPE_THERMO_EN
  input  logic             thermo,
`endif
  output logic [OUT_W-1:0] word
);

  // Refuse to elaborate outside the supported code widths
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_width
    $error("decoder_core: N_IN out of range");
  end

  // Each output bit compares its own index against the code
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    localparam logic [N_IN-1:0] IDX = N_IN'(i);
`ifdef DECODER_PIPE_THERMO_EN
    assign word[i] = thermo ? (x >= IDX) : (x == IDX);
`else
    assign word[i] = (x == IDX);
`endif
  end

endmodule

// File: rtl/decoder_pipe.sv
// Decodes binary codes into a two-entry skid buffer; thermometer mode under DECODER_PIPE_THERMO_EN (adds port thermo).
// Latency 1: an accepted code appears on y the cycle after acceptance when the buffer was empty.
// Valid/ready both sides; in_ready is a flop (drops only when full), so out_ready never reaches it combinationally.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter  int N_IN  = 3,
  localparam int OUT_W = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
`ifdef DECODER_PIPE_THERMO_EN
  input  logic             thermo,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_width
    $error("decoder_pipe: N_IN out of range");
  end

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   head_q, head_d;   // oldest entry, drives y
  logic [OUT_W-1:0]   tail_q, tail_d;   // younger entry, valid only in TWO
  logic               in_ready_q;
  logic [OUT_W-1:0]   dec_word;
  logic               in_xfer;
  logic               out_xfer;

  decoder_core #(.N_IN(N_IN)) u_core (
    .x      (x),
`ifdef DECODER_PIPE_THERMO_EN
    .thermo (thermo),
`endif
    .word   (dec_word)
  );

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  // head is cleared whenever the buffer drains, so y is zero in EMPTY
  assign y         = head_q;

  // Next occupancy and entry contents from the two transfer strobes
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          head_d  = dec_word;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = dec_word;
        end else if (in_xfer) begin
          state_d = TWO;
          tail_d  = dec_word;
        end else if (out_xfer) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      TWO: begin
        // in_ready is low here, so only a departure can happen
        if (out_xfer) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // State, entries and the registered ready flag; reset wins over any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != TWO);
    end
  end

endmodule
